// File: rtl/tanh_segment_search_ctrl.sv
// Binary-search segment locator for the tanh PWL unit, with one shared sign-magnitude comparator.
// Optional handshake counter (perf_cnt/perf_clr) is enabled by defining TANH_SEG_PERF_CNT_EN.

module fixed_point_comparator #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gte_b
);
  logic [WIDTH-2:FRAC_BITS] int_a, int_b;
  logic [FRAC_BITS-1:0]     frac_a, frac_b;
  logic                     mag_gte, mag_lte;

  assign int_a  = a[WIDTH-2:FRAC_BITS];
  assign int_b  = b[WIDTH-2:FRAC_BITS];
  assign frac_a = a[FRAC_BITS-1:0];
  assign frac_b = b[FRAC_BITS-1:0];

  assign mag_gte = (int_a > int_b) || ((int_a == int_b) && (frac_a >= frac_b));
  assign mag_lte = (int_a < int_b) || ((int_a == int_b) && (frac_a <= frac_b));

  // Negative values order by reversed magnitude, so -0 sits just below +0.
  always_comb begin
    a_gte_b = 1'b0;
    case ({a[WIDTH-1], b[WIDTH-1]})
      2'b00:   a_gte_b = mag_gte;
      2'b01:   a_gte_b = 1'b1;
      2'b10:   a_gte_b = 1'b0;
      default: a_gte_b = mag_lte;
    endcase
  end
endmodule

// state  | meaning
// IDLE   | ready for a sample; breakpoint writes accepted
// SEARCH | one breakpoint compare per cycle, MSB of the index first
// DONE   | result presented until out_ready
module tanh_segment_search_ctrl #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_seg,
  output logic [WIDTH-1:0] out_x,
`ifdef TANH_SEG_PERF_CNT_EN
  input  logic             perf_clr,
  output logic [15:0]      perf_cnt,
`endif
  output logic             busy
);
  localparam int NUM_BP = (1 << IDX_W) - 1;
  localparam int STEP_W = (IDX_W > 1) ? $clog2(IDX_W) : 1;
  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(NUM_BP);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]  tbl [NUM_BP];
  logic [WIDTH-1:0]  x_reg, cmp_b;
  logic [IDX_W-1:0]  seg_acc, cand;
  logic [STEP_W-1:0] step;
  logic              a_gte_b, in_hs, out_hs, cfg_ok;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  assign cfg_ok = cfg_we && (state == IDLE) && (cfg_addr != LAST_ADDR);
  assign cand   = seg_acc | (IDX_W'(1) << step);
  assign cmp_b  = tbl[cand - IDX_W'(1)];

  fixed_point_comparator #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_cmp (
    .a       (x_reg),
    .b       (cmp_b),
    .a_gte_b (a_gte_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_hs) state_nxt = SEARCH;
      SEARCH:  if (step == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BP; i++) tbl[i] <= '0;
    end else if (cfg_ok) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_we && !cfg_ok;
  end

  // Result registers load only on the final step so they hold across later samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg   <= '0;
      seg_acc <= '0;
      step    <= '0;
      out_seg <= '0;
      out_x   <= '0;
    end else if (in_hs) begin
      x_reg   <= in_x;
      seg_acc <= '0;
      step    <= STEP_W'(IDX_W - 1);
    end else if (state == SEARCH) begin
      if (a_gte_b) seg_acc <= cand;
      step <= step - 1'b1;
      if (step == '0) begin
        out_seg <= a_gte_b ? cand : seg_acc;
        out_x   <= x_reg;
      end
    end
  end

`ifdef TANH_SEG_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           perf_cnt <= '0;
    else if (perf_clr) perf_cnt <= '0;
    else if (out_hs)   perf_cnt <= perf_cnt + 16'd1;
  end
`else
  logic unused_out_hs;
  assign unused_out_hs = out_hs;
`endif
endmodule

// File: tb/tb_tanh_segment_search_ctrl.sv
// Scoreboard bench for tanh_segment_search_ctrl: directed samples against a breakpoint table of i-7.0.
// Covers the perf counter too when TANH_SEG_PERF_CNT_EN is defined.

module tb_tanh_segment_search_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_err;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_seg;
  logic [15:0] out_x;
  logic        busy;
`ifdef TANH_SEG_PERF_CNT_EN
  logic        perf_clr = 1'b0;
  logic [15:0] perf_cnt;
`endif

  tanh_segment_search_ctrl #(.WIDTH(16), .FRAC_BITS(8), .IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_seg   (out_seg),
    .out_x     (out_x),
`ifdef TANH_SEG_PERF_CNT_EN
    .perf_clr  (perf_clr),
    .perf_cnt  (perf_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] x;
    logic [3:0]  seg;
    int          acc;
  } exp_t;
  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitor: each rising out_valid is one result; compare it against the oldest expectation.
  logic prev_valid = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          timeout_fail("unexpected_output");
        end else begin
          mon_e = sb_q.pop_front();
          check("out_seg", 32'(out_seg), 32'(mon_e.seg));
          check("out_x", 32'(out_x), 32'(mon_e.x));
          check("latency", 32'(cyc - mon_e.acc), 32'd4);
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input logic [15:0] x, input logic [3:0] seg, input bit push);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = x;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timeout_fail("send_wait");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) sb_q.push_back('{x, seg, cyc});
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0 || !in_ready) timeout_fail("drain_wait");
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [15:0] data, input logic exp_err);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check("cfg_err_after_write", 32'(cfg_err), 32'(exp_err));
  endtask

  typedef struct {
    logic [15:0] x;
    logic [3:0]  seg;
  } vec_t;
  vec_t vecs[9] = '{
    '{16'h0080, 4'd8},  '{16'h8700, 4'd1},  '{16'h8800, 4'd0},
    '{16'h7FFF, 4'd15}, '{16'h8000, 4'd7},  '{16'h0000, 4'd8},
    '{16'h8100, 4'd7},  '{16'h0700, 4'd15}, '{16'h06FF, 4'd14}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bp;
    int n;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_seg", 32'(out_seg), 32'd0);
    check("rst_out_x", 32'(out_x), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Breakpoints -7.0 .. +7.0 in S7.8 sign-magnitude.
    for (int i = 0; i < 15; i++) begin
      if (i < 7) bp = {1'b1, 7'(7 - i), 8'h00};
      else       bp = {1'b0, 7'(i - 7), 8'h00};
      cfg_write(4'(i), bp, 1'b0);
    end

    for (int i = 0; i < 9; i++) send(vecs[i].x, vecs[i].seg, 1'b1);
    wait_drain();

    // Back-pressure: result held while out_ready is low.
    out_ready = 1'b0;
    send(16'h0300, 4'd11, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout_fail("bp_valid_wait");
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_seg", 32'(out_seg), 32'd11);
      check("bp_out_x", 32'(out_x), 32'h0300);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    wait_drain();

    // Rejected write while searching.
    send(16'h0080, 4'd8, 1'b1);
    cfg_we   = 1'b1;
    cfg_addr = 4'd7;
    cfg_data = 16'h7FFF;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check("busy_write_err", 32'(cfg_err), 32'd1);
    @(posedge clk);
    #1;
    check("busy_write_err_clear", 32'(cfg_err), 32'd0);
    wait_drain();

    // Out-of-range address in IDLE, single then back-to-back.
    cfg_write(4'd15, 16'h1234, 1'b1);
    @(posedge clk);
    #1;
    check("addr15_err_clear", 32'(cfg_err), 32'd0);
    cfg_write(4'd15, 16'h0001, 1'b1);
    cfg_write(4'd15, 16'h0002, 1'b1);
    @(posedge clk);
    #1;
    check("b2b_err_clear", 32'(cfg_err), 32'd0);
    send(16'h0080, 4'd8, 1'b1);
    send(16'h8000, 4'd7, 1'b1);
    wait_drain();

    // Write and sample accept on the same edge: search sees the new entry.
    @(posedge clk);
    #1;
    cfg_we   = 1'b1;
    cfg_addr = 4'd8;
    cfg_data = 16'h0040;
    send(16'h0080, 4'd9, 1'b1);
    cfg_we = 1'b0;
    check("same_edge_err", 32'(cfg_err), 32'd0);
    send(16'h0030, 4'd8, 1'b1);
    wait_drain();

    // Reset mid-search: no output for the aborted sample, table cleared.
    @(posedge clk);
    #1;
    send(16'h0080, 4'd0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_seg", 32'(out_seg), 32'd0);
    check("midrst_out_x", 32'(out_x), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(16'h0100, 4'd15, 1'b1);
    send(16'h8100, 4'd0, 1'b1);
    send(16'h0000, 4'd15, 1'b1);
    wait_drain();

`ifdef TANH_SEG_PERF_CNT_EN
    @(negedge clk);
    check("perf_cnt_three", 32'(perf_cnt), 32'd3);
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    check("perf_cnt_clr", 32'(perf_cnt), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
